cfg_sram_bank: RTL and testbench

Parametrised configuration-memory bank: a DEPTH x DATA_WIDTH array of BL/WL-programmed configuration cells plus the sequencer that drives them. It accepts word writes over a valid/ready handshake and generates timed BL/WL pulses. It models the resulting cell state and exposes all stored bits as flat dout/doutb vectors to the fabric. It supports single-phase SRAM programming and two-phase RRAM (reset-then-set) programming.

---
 rtl/cfg_sram_bank.sv | 170 +++++++++++++++++
 tb/tb_cfg_sram_bank.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cfg_sram_bank.sv
// cfg_sram_bank: DEPTH x DATA_WIDTH configuration-cell bank with its BL/WL
// programming sequencer. Writes arrive over a valid/ready handshake; the
// sequencer walks SETUP -> PULSE -> HOLD once (SRAM) or twice (RRAM reset
// pass, then set pass) and the modelled cell contents appear on dout/doutb.
// Optional readback port: define CFG_SRAM_BANK_READBACK_EN to add
// rd_addr/rd_data (registered, 1-cycle latency).
module cfg_sram_bank #(
    parameter int DATA_WIDTH   = 8,
    parameter int DEPTH        = 16,
    parameter int ADDR_WIDTH   = 4,
    parameter int PULSE_CYCLES = 2,
    parameter int RRAM_MODE    = 0
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        wr_valid,
    output logic                        wr_ready,
    input  logic [ADDR_WIDTH-1:0]       wr_addr,
    input  logic [DATA_WIDTH-1:0]       wr_data,
    output logic [DATA_WIDTH-1:0]       bl,
    output logic [DATA_WIDTH-1:0]       blb,
    output logic [DEPTH-1:0]            wl,
    output logic                        busy,
    output logic                        done,
    output logic                        addr_err,
    output logic [DEPTH*DATA_WIDTH-1:0] dout,
    output logic [DEPTH*DATA_WIDTH-1:0] doutb
`ifdef CFG_SRAM_BANK_READBACK_EN
    ,
    input  logic [ADDR_WIDTH-1:0]       rd_addr,
    output logic [DATA_WIDTH-1:0]       rd_data
`endif
);

    localparam int CW = $clog2(PULSE_CYCLES + 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t                        state, state_nx;
    logic                          phase, phase_nx;
    logic [CW-1:0]                 cnt, cnt_nx;
    logic [ADDR_WIDTH-1:0]         addr_q;
    logic [DATA_WIDTH-1:0]         data_q;
    logic [DEPTH*DATA_WIDTH-1:0]   cells;
    logic                          addr_ok;
    logic                          last_pulse;
    logic                          final_phase;

    // An out-of-range address still runs the full sequence but never
    // touches a word line or a cell.
    assign addr_ok     = ({1'b0, addr_q} < DEPTH_L);
    assign last_pulse  = (state == PULSE) && (cnt == '0);
    assign final_phase = (RRAM_MODE == 0) || phase;

    // Sequencer state, pass number and pulse down-counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            phase <= 1'b0;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            phase <= phase_nx;
            cnt   <= cnt_nx;
        end
    end

    // Next-state logic; RRAM loops back to SETUP once for the set pass.
    always_comb begin
        state_nx = state;
        phase_nx = phase;
        cnt_nx   = cnt;
        case (state)
            IDLE: begin
                if (wr_valid) begin
                    state_nx = SETUP;
                    phase_nx = 1'b0;
                end
            end
            SETUP: begin
                state_nx = PULSE;
                cnt_nx   = CW'(PULSE_CYCLES - 1);
            end
            PULSE: begin
                if (cnt == '0) state_nx = HOLD;
                else           cnt_nx   = cnt - CW'(1);
            end
            HOLD: begin
                if (final_phase) begin
                    state_nx = IDLE;
                    phase_nx = 1'b0;
                end else begin
                    state_nx = SETUP;
                    phase_nx = 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Capture address and data on acceptance so later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_q <= '0;
            data_q <= '0;
        end else if ((state == IDLE) && wr_valid) begin
            addr_q <= wr_addr;
            data_q <= wr_data;
        end
    end

    // Line drivers: the RRAM reset pass drives the complement on blb only.
    always_comb begin
        wr_ready = (state == IDLE);
        busy     = (state != IDLE);
        done     = (state == HOLD) && final_phase;
        addr_err = (state == HOLD) && final_phase && !addr_ok;
        bl       = '0;
        blb      = '0;
        if (state != IDLE) begin
            if ((RRAM_MODE != 0) && !phase) blb = ~data_q;
            else                            bl  = data_q;
        end
        for (int w = 0; w < DEPTH; w++) begin
            wl[w] = (state == PULSE) && ({1'b0, addr_q} == (ADDR_WIDTH + 1)'(w));
        end
    end

    // Cell model: updated on the edge that ends the last pulse cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            cells <= '0;
        end else if (last_pulse) begin
            for (int w = 0; w < DEPTH; w++) begin
                if ({1'b0, addr_q} == (ADDR_WIDTH + 1)'(w)) begin
                    if (RRAM_MODE == 0)
                        cells[w*DATA_WIDTH +: DATA_WIDTH] <= data_q;
                    else if (!phase)
                        cells[w*DATA_WIDTH +: DATA_WIDTH] <= cells[w*DATA_WIDTH +: DATA_WIDTH] & ~blb;
                    else
                        cells[w*DATA_WIDTH +: DATA_WIDTH] <= cells[w*DATA_WIDTH +: DATA_WIDTH] | bl;
                end
            end
        end
    end

    assign dout  = cells;
    assign doutb = ~cells;

`ifdef CFG_SRAM_BANK_READBACK_EN
    logic [DATA_WIDTH-1:0] rd_word;

    // Select the addressed word; out-of-range reads return zero.
    always_comb begin
        rd_word = '0;
        for (int w = 0; w < DEPTH; w++) begin
            if ({1'b0, rd_addr} == (ADDR_WIDTH + 1)'(w))
                rd_word = cells[w*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Register the read so it shows the pre-update value until the update edge.
    always_ff @(posedge clk) begin
        if (rst) rd_data <= '0;
        else     rd_data <= rd_word;
    end
`endif

endmodule

// File: tb/tb_cfg_sram_bank.sv
// tb_cfg_sram_bank: directed checks on three bank instances -- default SRAM,
// RRAM two-pass, and a DEPTH=12 bank for out-of-range addressing.
module tb_cfg_sram_bank;

    localparam int P = 2;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;
    bit   s_multi_wl = 1'b0;

    logic         s_valid, s_ready, s_busy, s_done, s_aerr;
    logic [3:0]   s_addr;
    logic [7:0]   s_data, s_bl, s_blb;
    logic [15:0]  s_wl;
    logic [127:0] s_dout, s_doutb;

    logic         r_valid, r_ready, r_busy, r_done, r_aerr;
    logic [3:0]   r_addr;
    logic [7:0]   r_data, r_bl, r_blb;
    logic [15:0]  r_wl;
    logic [127:0] r_dout, r_doutb;

    logic         d_valid, d_ready, d_busy, d_done, d_aerr;
    logic [3:0]   d_addr;
    logic [7:0]   d_data, d_bl, d_blb;
    logic [11:0]  d_wl;
    logic [95:0]  d_dout, d_doutb;

`ifdef CFG_SRAM_BANK_READBACK_EN
    logic [3:0] s_rd_addr, r_rd_addr, d_rd_addr;
    logic [7:0] s_rd_data, r_rd_data, d_rd_data;
`endif

    always #5 clk = ~clk;

    cfg_sram_bank u_sram (
        .clk(clk), .rst(rst), .wr_valid(s_valid), .wr_ready(s_ready),
        .wr_addr(s_addr), .wr_data(s_data), .bl(s_bl), .blb(s_blb), .wl(s_wl),
        .busy(s_busy), .done(s_done), .addr_err(s_aerr), .dout(s_dout), .doutb(s_doutb)
`ifdef CFG_SRAM_BANK_READBACK_EN
        , .rd_addr(s_rd_addr), .rd_data(s_rd_data)
`endif
    );

    cfg_sram_bank #(.RRAM_MODE(1)) u_rram (
        .clk(clk), .rst(rst), .wr_valid(r_valid), .wr_ready(r_ready),
        .wr_addr(r_addr), .wr_data(r_data), .bl(r_bl), .blb(r_blb), .wl(r_wl),
        .busy(r_busy), .done(r_done), .addr_err(r_aerr), .dout(r_dout), .doutb(r_doutb)
`ifdef CFG_SRAM_BANK_READBACK_EN
        , .rd_addr(r_rd_addr), .rd_data(r_rd_data)
`endif
    );

    cfg_sram_bank #(.DEPTH(12)) u_d12 (
        .clk(clk), .rst(rst), .wr_valid(d_valid), .wr_ready(d_ready),
        .wr_addr(d_addr), .wr_data(d_data), .bl(d_bl), .blb(d_blb), .wl(d_wl),
        .busy(d_busy), .done(d_done), .addr_err(d_aerr), .dout(d_dout), .doutb(d_doutb)
`ifdef CFG_SRAM_BANK_READBACK_EN
        , .rd_addr(d_rd_addr), .rd_data(d_rd_data)
`endif
    );

    // Flag any cycle where the SRAM bank drives more than one word line.
    always @(negedge clk) begin
        if ($countones(s_wl) > 1) s_multi_wl = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        checks++; if (s_dout !== 128'h0) begin failures++; $display("[TB] FAIL reset_dout: got %0h expected 0", s_dout); end
        checks++; if (s_doutb !== {128{1'b1}}) begin failures++; $display("[TB] FAIL reset_doutb: got %0h expected all ones", s_doutb); end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %0b expected 1", s_ready); end
        checks++; if (s_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %0b expected 0", s_busy); end
        checks++; if (s_wl !== 16'h0) begin failures++; $display("[TB] FAIL reset_wl: got %0h expected 0", s_wl); end
        checks++; if ({s_bl, s_blb} !== 16'h0) begin failures++; $display("[TB] FAIL reset_lines: got %0h expected 0", {s_bl, s_blb}); end
        checks++; if ({s_done, s_aerr} !== 2'b00) begin failures++; $display("[TB] FAIL reset_done: got %0b expected 00", {s_done, s_aerr}); end
        checks++; if (r_dout !== 128'h0 || d_doutb !== {96{1'b1}}) begin failures++; $display("[TB] FAIL reset_others: got %0h/%0h expected 0/all ones", r_dout, d_doutb); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_sram_write();
        s_addr = 4'd3; s_data = 8'hA5; s_valid = 1'b1;
        step();
        s_valid = 1'b0; s_data = 8'h00; s_addr = 4'd7;
        checks++; if (s_bl !== 8'hA5 || s_wl !== 16'h0 || s_busy !== 1'b1) begin failures++; $display("[TB] FAIL sram_setup: got bl=%0h wl=%0h busy=%0b expected bl=a5 wl=0 busy=1", s_bl, s_wl, s_busy); end
        step();
        checks++; if (s_wl !== 16'h0008) begin failures++; $display("[TB] FAIL sram_pulse1: got %0h expected 8", s_wl); end
        step();
        checks++; if (s_wl !== 16'h0008 || s_done !== 1'b0) begin failures++; $display("[TB] FAIL sram_pulse2: got wl=%0h done=%0b expected wl=8 done=0", s_wl, s_done); end
        step();
        checks++; if (s_done !== 1'b1 || s_aerr !== 1'b0 || s_wl !== 16'h0) begin failures++; $display("[TB] FAIL sram_done: got done=%0b err=%0b wl=%0h expected 1/0/0", s_done, s_aerr, s_wl); end
        checks++; if (s_dout[31:24] !== 8'hA5 || s_doutb[31:24] !== 8'h5A) begin failures++; $display("[TB] FAIL sram_word3: got %0h/%0h expected a5/5a", s_dout[31:24], s_doutb[31:24]); end
        step();
        checks++; if (s_ready !== 1'b1 || s_done !== 1'b0) begin failures++; $display("[TB] FAIL sram_ready: got ready=%0b done=%0b expected 1/0", s_ready, s_done); end
    endtask

    task automatic test_rram();
        bit seen;
        bit prev;
        int pulses;
        r_addr = 4'd5; r_data = 8'hF0; r_valid = 1'b1;
        step();
        r_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (r_done === 1'b1) seen = 1'b1;
            else step();
        end
        checks++; if (!seen || r_dout[47:40] !== 8'hF0) begin failures++; $display("[TB] FAIL rram_preload: got seen=%0b word=%0h expected 1/f0", seen, r_dout[47:40]); end
        step();
        r_data = 8'h3C; r_valid = 1'b1;
        step();
        r_valid = 1'b0; r_data = 8'hFF;
        seen = 1'b0; prev = 1'b0; pulses = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (r_wl !== 16'h0) begin
                pulses++;
                checks++; if (r_wl !== 16'h0020) begin failures++; $display("[TB] FAIL rram_wl: got %0h expected 20", r_wl); end
                if (pulses <= P) begin
                    checks++; if (r_blb !== 8'hC3 || r_bl !== 8'h00) begin failures++; $display("[TB] FAIL rram_reset_lines: got bl=%0h blb=%0h expected 0/c3", r_bl, r_blb); end
                end else begin
                    checks++; if (r_bl !== 8'h3C || r_blb !== 8'h00) begin failures++; $display("[TB] FAIL rram_set_lines: got bl=%0h blb=%0h expected 3c/0", r_bl, r_blb); end
                end
            end else if (prev && pulses == P) begin
                checks++; if (r_dout[47:40] !== 8'h30 || r_done !== 1'b0) begin failures++; $display("[TB] FAIL rram_after_reset: got word=%0h done=%0b expected 30/0", r_dout[47:40], r_done); end
            end
            if (r_done === 1'b1) begin
                seen = 1'b1;
                checks++; if (r_dout[47:40] !== 8'h3C) begin failures++; $display("[TB] FAIL rram_final_word: got %0h expected 3c", r_dout[47:40]); end
                checks++; if (pulses != 2 * P) begin failures++; $display("[TB] FAIL rram_pulse_count: got %0d expected %0d", pulses, 2 * P); end
            end
            prev = (r_wl !== 16'h0);
            if (!seen) step();
        end
        checks++; if (!seen) begin failures++; $display("[TB] FAIL rram_timeout: got no done expected done"); end
        step();
        checks++; if (r_ready !== 1'b1 || r_done !== 1'b0) begin failures++; $display("[TB] FAIL rram_ready: got ready=%0b done=%0b expected 1/0", r_ready, r_done); end
    endtask

    task automatic test_back_to_back();
        s_addr = 4'd0; s_data = 8'h5A; s_valid = 1'b1;
        step();
        s_addr = 4'd15; s_data = 8'hC3;
        step();
        checks++; if (s_wl !== 16'h0001) begin failures++; $display("[TB] FAIL b2b_wl0: got %0h expected 1", s_wl); end
        step();
        step();
        checks++; if (s_done !== 1'b1 || s_dout[7:0] !== 8'h5A) begin failures++; $display("[TB] FAIL b2b_first_done: got done=%0b word=%0h expected 1/5a", s_done, s_dout[7:0]); end
        step();
        checks++; if (s_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_idle: got %0b expected 1", s_ready); end
        step();
        s_valid = 1'b0;
        checks++; if (s_busy !== 1'b1 || s_bl !== 8'hC3) begin failures++; $display("[TB] FAIL b2b_second_accept: got busy=%0b bl=%0h expected 1/c3", s_busy, s_bl); end
        step();
        checks++; if (s_wl !== 16'h8000) begin failures++; $display("[TB] FAIL b2b_wl15: got %0h expected 8000", s_wl); end
        step();
        step();
        checks++; if (s_done !== 1'b1 || s_dout[127:120] !== 8'hC3 || s_dout[7:0] !== 8'h5A) begin failures++; $display("[TB] FAIL b2b_second_done: got done=%0b w15=%0h w0=%0h expected 1/c3/5a", s_done, s_dout[127:120], s_dout[7:0]); end
        step();
        checks++; if (s_multi_wl) begin failures++; $display("[TB] FAIL b2b_onehot: got multiple wl bits expected at most one"); end
    endtask

    task automatic test_addr_range();
        bit seen;
        bit wl_seen;
        d_addr = 4'd11; d_data = 8'h81; d_valid = 1'b1;
        step();
        d_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (d_done === 1'b1) seen = 1'b1;
            else step();
        end
        checks++; if (!seen || d_aerr !== 1'b0 || d_dout[95:88] !== 8'h81) begin failures++; $display("[TB] FAIL range_last_word: got seen=%0b err=%0b word=%0h expected 1/0/81", seen, d_aerr, d_dout[95:88]); end
        step();
        d_addr = 4'd13; d_data = 8'hFF; d_valid = 1'b1;
        step();
        d_valid = 1'b0;
        seen = 1'b0; wl_seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            if (d_wl !== 12'h0) wl_seen = 1'b1;
            if (d_done === 1'b1) seen = 1'b1;
            else step();
        end
        checks++; if (!seen || d_aerr !== 1'b1) begin failures++; $display("[TB] FAIL range_addr_err: got seen=%0b err=%0b expected 1/1", seen, d_aerr); end
        checks++; if (d_dout !== {8'h81, 88'h0}) begin failures++; $display("[TB] FAIL range_dout: got %0h expected 81 in word 11 only", d_dout); end
        checks++; if (wl_seen) begin failures++; $display("[TB] FAIL range_wl: got wl asserted expected none"); end
        step();
        checks++; if (d_aerr !== 1'b0 || d_ready !== 1'b1) begin failures++; $display("[TB] FAIL range_err_pulse: got err=%0b ready=%0b expected 0/1", d_aerr, d_ready); end
    endtask

`ifdef CFG_SRAM_BANK_READBACK_EN
    task automatic test_readback();
        s_rd_addr = 4'd3; d_rd_addr = 4'd13;
        step();
        checks++; if (s_rd_data !== 8'hA5) begin failures++; $display("[TB] FAIL rd_word3: got %0h expected a5", s_rd_data); end
        checks++; if (d_rd_data !== 8'h00) begin failures++; $display("[TB] FAIL rd_out_of_range: got %0h expected 0", d_rd_data); end
    endtask
`endif

    task automatic test_reset_midop();
        bit done_seen;
`ifdef CFG_SRAM_BANK_READBACK_EN
        s_rd_addr = 4'd2;
`endif
        s_addr = 4'd2; s_data = 8'h77; s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        step();
        checks++; if (s_wl !== 16'h0004) begin failures++; $display("[TB] FAIL midop_pulse: got %0h expected 4", s_wl); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (s_wl !== 16'h0 || s_dout !== 128'h0 || s_doutb !== {128{1'b1}}) begin failures++; $display("[TB] FAIL midop_cleared: got wl=%0h dout=%0h expected 0/0", s_wl, s_dout); end
        checks++; if (s_ready !== 1'b1 || s_done !== 1'b0) begin failures++; $display("[TB] FAIL midop_idle: got ready=%0b done=%0b expected 1/0", s_ready, s_done); end
        done_seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (s_done === 1'b1) done_seen = 1'b1;
            step();
        end
        checks++; if (done_seen) begin failures++; $display("[TB] FAIL midop_no_done: got done expected none"); end
`ifdef CFG_SRAM_BANK_READBACK_EN
        checks++; if (s_rd_data !== 8'h00) begin failures++; $display("[TB] FAIL midop_readback: got %0h expected 0", s_rd_data); end
`endif
    endtask

    // Run every scenario in order, then report.
    initial begin
        rst = 1'b1;
        s_valid = 1'b0; s_addr = '0; s_data = '0;
        r_valid = 1'b0; r_addr = '0; r_data = '0;
        d_valid = 1'b0; d_addr = '0; d_data = '0;
`ifdef CFG_SRAM_BANK_READBACK_EN
        s_rd_addr = '0; r_rd_addr = '0; d_rd_addr = '0;
`endif
        test_reset();
        test_sram_write();
        test_rram();
        test_back_to_back();
        test_addr_range();
`ifdef CFG_SRAM_BANK_READBACK_EN
        test_readback();
`endif
        test_reset_midop();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
